// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-master data-bus arbiter.
// Optional feature macro: BUS_ARB_FIXED_PRIO_EN (see arb_pick / bus_arbiter).
package bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic [1:0] BHW_BYTE = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_WORD = 2'b10;

    localparam int MAX_BURST_DEF = 8;
    localparam int CNT_W_DEF     = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  bhw;
    } bus_req_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way picker shared by the idle and release arbitration paths.
// BUS_ARB_FIXED_PRIO_EN: master 0 wins every contention instead of round-robin.
module arb_pick
    import bus_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic valid,
    output logic sel
);

    assign valid = req0 | req1;

`ifdef BUS_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = rr_last;
    assign sel       = ~req0;
`else
    // On contention the master that was not served last wins.
    assign sel = (req0 & req1) ? ~rr_last : req1;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin data-bus arbiter with locked bursts capped at MAX_BURST.
// BUS_ARB_FIXED_PRIO_EN selects fixed priority (master 0 wins contention).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [1:0]  m0_bhw,
    input  logic [1:0]  m1_bhw,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] DAddr,
    output logic [31:0] DWrData,
    output logic        DWe,
    output logic [1:0]  BHW,
    input  logic [31:0] DRdData,
    output logic [1:0]  state_dbg
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

    logic [1:0]       state, state_n;
    logic             rr_last, rr_n;
    logic [CNT_W-1:0] burst_cnt, cnt_n;

    logic pick_valid, pick_sel;

    arb_pick u_pick (
        .req0    (m0_req),
        .req1    (m1_req),
        .rr_last (rr_last),
        .valid   (pick_valid),
        .sel     (pick_sel)
    );

    logic own_req, own_lock, oth_req, arb;

    always_comb begin
        state_n  = state;
        rr_n     = rr_last;
        cnt_n    = burst_cnt;
        arb      = 1'b0;
        own_req  = (state == ST_GNT1) ? m1_req  : m0_req;
        own_lock = (state == ST_GNT1) ? m1_lock : m0_lock;
        oth_req  = (state == ST_GNT1) ? m0_req  : m1_req;
        case (state)
            ST_GNT0, ST_GNT1: begin
                if (own_req && own_lock && (burst_cnt < CAP || !oth_req)) begin
                    if (burst_cnt != '1)
                        cnt_n = burst_cnt + CNT_W'(1);
                end else if (own_req && own_lock) begin
                    // Cap reached with the other side waiting: hand over directly,
                    // so fixed priority cannot re-grant the capped master.
                    state_n = (state == ST_GNT0) ? ST_GNT1 : ST_GNT0;
                    rr_n    = (state == ST_GNT0);
                    cnt_n   = '0;
                end else begin
                    arb = 1'b1;
                end
            end
            default: arb = 1'b1;
        endcase
        if (arb) begin
            cnt_n = '0;
            if (pick_valid) begin
                state_n = pick_sel ? ST_GNT1 : ST_GNT0;
                rr_n    = pick_sel;
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            rr_last   <= rr_n;
            burst_cnt <= cnt_n;
        end
    end

    assign state_dbg = state;
    assign m0_gnt    = (state == ST_GNT0);
    assign m1_gnt    = (state == ST_GNT1);

    // A transfer happens only while granted and requesting, never during reset.
    assign m0_ready = m0_gnt & m0_req & ~reset;
    assign m1_ready = m1_gnt & m1_req & ~reset;
    assign m0_rdata = m0_ready ? DRdData : 32'd0;
    assign m1_rdata = m1_ready ? DRdData : 32'd0;

    bus_req_t m0_bus, m1_bus, sel_bus;

    assign m0_bus = '{addr: m0_addr, wdata: m0_wdata, we: m0_we, bhw: m0_bhw};
    assign m1_bus = '{addr: m1_addr, wdata: m1_wdata, we: m1_we, bhw: m1_bhw};

    always_comb begin
        sel_bus = '0;
        if (m0_gnt)
            sel_bus = m0_bus;
        else if (m1_gnt)
            sel_bus = m1_bus;
    end

    assign DAddr   = sel_bus.addr;
    assign DWrData = sel_bus.wdata;
    assign BHW     = sel_bus.bhw;
    assign DWe     = (m0_ready & m0_we) | (m1_ready & m1_we);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_BURST=4).
// Contention ordering section follows BUS_ARB_FIXED_PRIO_EN.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_we, m1_we;
    logic [1:0]  m0_bhw, m1_bhw;
    logic        m0_gnt, m1_gnt, m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] DAddr, DWrData, DRdData;
    logic        DWe;
    logic [1:0]  BHW;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_we(m0_we), .m1_we(m1_we), .m0_bhw(m0_bhw), .m1_bhw(m1_bhw),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ready(m0_ready), .m1_ready(m1_ready),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .DAddr(DAddr), .DWrData(DWrData), .DWe(DWe), .BHW(BHW), .DRdData(DRdData),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drop_all();
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        m0_we = 0; m1_we = 0; DRdData = 0;
    endtask

    initial begin
        reset = 1;
        drop_all();
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_bhw = 0; m1_bhw = 0;

        // Reset state
        step(); step(); #1;
        chk("rst_dwe", DWe, 0);
        chk("rst_gnt0", m0_gnt, 0);
        chk("rst_gnt1", m1_gnt, 0);
        chk("rst_state", state_dbg, ST_IDLE);

        // Single-master write
        step(); reset = 0; m0_req = 1; m0_we = 1; m0_addr = 32'h2000_0204;
        m0_wdata = 32'hDEAD_BEEF; m0_bhw = BHW_WORD; #1;
        chk("t1_idle_gnt0", m0_gnt, 0);
        chk("t1_idle_dwe", DWe, 0);
        chk("t1_idle_daddr", DAddr, 0);
        step(); #1;
        chk("t1_gnt0", m0_gnt, 1);
        chk("t1_gnt1", m1_gnt, 0);
        chk("t1_dwe", DWe, 1);
        chk("t1_daddr", DAddr, 32'h2000_0204);
        chk("t1_dwrdata", DWrData, 32'hDEAD_BEEF);
        chk("t1_bhw", BHW, BHW_WORD);
        chk("t1_ready0", m0_ready, 1);
        chk("t1_ready1", m1_ready, 0);
        step(); m0_req = 0; #1;
        chk("t1_held_gnt0", m0_gnt, 1);
        chk("t1_held_dwe", DWe, 0);
        chk("t1_held_ready0", m0_ready, 0);
        step(); #1;
        chk("t1_end_state", state_dbg, ST_IDLE);
        chk("t1_end_gnt0", m0_gnt, 0);
        chk("t1_end_dwe", DWe, 0);
        drop_all();

`ifndef BUS_ARB_FIXED_PRIO_EN
        // Contention after reset alternates 0,1,0,1
        step(); reset = 1; #1;
        step(); reset = 0; m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 1;
        m1_addr = 32'h3000_0010; m1_wdata = 32'h1234_5678; m1_bhw = BHW_HALF; #1;
        chk("t2_idle", state_dbg, ST_IDLE);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk($sformatf("t2_gnt0_c%0d", i), m0_gnt, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t2_gnt1_c%0d", i), m1_gnt, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("t2_dwe_c%0d", i), DWe, (i % 2 == 1) ? 1 : 0);
        end
        step(); drop_all();
        step(); step(); #1;
        chk("t2_end_state", state_dbg, ST_IDLE);
`endif

        // Read path through master 1
        step(); m1_req = 1; m1_we = 0; m1_addr = 32'h4000_0100; m1_bhw = BHW_BYTE;
        DRdData = 32'h0000_00A5; #1;
        step(); #1;
        chk("t3_gnt1", m1_gnt, 1);
        chk("t3_ready1", m1_ready, 1);
        chk("t3_rdata1", m1_rdata, 32'h0000_00A5);
        chk("t3_rdata0", m0_rdata, 0);
        chk("t3_ready0", m0_ready, 0);
        chk("t3_dwe", DWe, 0);
        chk("t3_daddr", DAddr, 32'h4000_0100);
        chk("t3_bhw", BHW, BHW_BYTE);
        step(); drop_all();
        step(); #1;
        chk("t3_end_state", state_dbg, ST_IDLE);

        // Locked m0 burst capped at 4 beats once m1 requests
        step(); m0_req = 1; m0_lock = 1; m0_we = 1; m0_addr = 32'h2000_0300; #1;
        step(); m1_req = 1; m1_we = 0; m1_addr = 32'h4000_0004; #1;
        chk("t4_beat1_ready0", m0_ready, 1);
        for (int b = 2; b <= 4; b++) begin
            step(); #1;
            chk($sformatf("t4_beat%0d_ready0", b), m0_ready, 1);
            chk($sformatf("t4_beat%0d_gnt1", b), m1_gnt, 0);
        end
        step(); #1;
        chk("t4_handoff_gnt1", m1_gnt, 1);
        chk("t4_handoff_gnt0", m0_gnt, 0);
        chk("t4_handoff_ready1", m1_ready, 1);
        step(); drop_all();
        step(); step(); #1;
        chk("t4_end_state", state_dbg, ST_IDLE);

        // Same burst with m1 idle runs past the cap
        step(); m0_req = 1; m0_lock = 1; m0_we = 1; #1;
        for (int b = 1; b <= 6; b++) begin
            step(); #1;
            chk($sformatf("t4b_beat%0d_ready0", b), m0_ready, 1);
            chk($sformatf("t4b_beat%0d_gnt0", b), m0_gnt, 1);
        end
        step(); drop_all();
        step(); step(); #1;
        chk("t4b_end_state", state_dbg, ST_IDLE);

        // Reset in the middle of a locked m1 write burst
        step(); m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 32'h3000_0020; #1;
        step(); #1;
        chk("t5_beat1_dwe", DWe, 1);
        step(); reset = 1; #1;
        chk("t5_rst_dwe", DWe, 0);
        chk("t5_rst_ready1", m1_ready, 0);
        chk("t5_rst_gnt1", m1_gnt, 1);
        step(); reset = 0; m1_lock = 0; m1_we = 0; m0_req = 1; m0_we = 0; #1;
        chk("t5_after_gnt0", m0_gnt, 0);
        chk("t5_after_gnt1", m1_gnt, 0);
        chk("t5_after_state", state_dbg, ST_IDLE);
        step(); #1;
        chk("t5_cont_gnt0", m0_gnt, 1);
        chk("t5_cont_gnt1", m1_gnt, 0);
        step(); drop_all();
        step(); step(); #1;
        chk("t5_end_state", state_dbg, ST_IDLE);

`ifdef BUS_ARB_FIXED_PRIO_EN
        // Fixed priority: m0 holds the bus while both request
        step(); m0_req = 1; m1_req = 1; #1;
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            chk($sformatf("fp_gnt0_c%0d", i), m0_gnt, 1);
            chk($sformatf("fp_gnt1_c%0d", i), m1_gnt, 0);
        end
        step(); m0_req = 0; #1;
        step(); #1;
        chk("fp_handoff_gnt1", m1_gnt, 1);
        step(); drop_all();
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
